// File: rtl/mem_access_unit_if.sv
// Data-bus handshake between the memory access unit (master) and the data memory/bus (slave).
interface mem_access_unit_if;
   logic [31:0] dAddr;
   logic [31:0] dWdata;
   logic [3:0]  dBe;
   logic        dWe;
   logic        dReq;
   logic        dAck;
   logic [31:0] dRdata;

   modport master (output dAddr, dWdata, dBe, dWe, dReq, input dAck, dRdata);
   modport slave  (input dAddr, dWdata, dBe, dWe, dReq, output dAck, dRdata);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: IDLE/BUSY/DONE bus FSM with byte lanes, load extension and watchdog.
// Optional MISALIGN_TRAP_EN: misaligned halfword/word accesses pulse misalign instead of going to the bus.
module mem_access_unit (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       AluOut,
   input  logic [31:0]       storeData,
   input  logic [2:0]        fnc3,
   input  logic              memRead,
   input  logic              memWrite,
   mem_access_unit_if.master bus,
   output logic [31:0]       loadData,
   output logic              stall,
   output logic              busErr,
   output logic              misalign
);
   localparam int NUM_LANES = 4;
   localparam int VEC_W     = 8;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                          state;
   logic [7:0]                      wdog;
   logic [2:0]                      fnc_q;
   logic [1:0]                      off_q;
   logic                            req, mis, accept;
   logic [NUM_LANES-1:0][VEC_W-1:0] wlane;
   logic [NUM_LANES-1:0]            be;
   logic [31:0]                     rsh_b, rsh_h, ext;

   assign req = memRead | memWrite;
`ifdef MISALIGN_TRAP_EN
   assign mis = (fnc3[1:0] == 2'b01 && AluOut[0]) || (fnc3[1] && AluOut[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif
   assign accept = req & ~mis;
   assign stall  = (state == IDLE && accept) || state == BUSY;

   // Per-lane store replication and enables; reads and words enable every lane.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [1:0] LI = 2'(i);
      assign wlane[i] = fnc3[1] ? storeData[VEC_W*i +: VEC_W]
                      : fnc3[0] ? storeData[VEC_W*(i%2) +: VEC_W]
                      : storeData[VEC_W-1:0];
      assign be[i] = ~memWrite | fnc3[1] |
                     (fnc3[0] ? (AluOut[1] == LI[1]) : (AluOut[1:0] == LI));
   end

   assign rsh_b = bus.dRdata >> {off_q, 3'b000};
   assign rsh_h = bus.dRdata >> {off_q[1], 4'b0000};

   always_comb begin
      ext = bus.dRdata;
      case (fnc_q[1:0])
         2'b00:   ext = {{24{rsh_b[7]  & ~fnc_q[2]}}, rsh_b[7:0]};
         2'b01:   ext = {{16{rsh_h[15] & ~fnc_q[2]}}, rsh_h[15:0]};
         default: ext = bus.dRdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         wdog       <= '0;
         fnc_q      <= '0;
         off_q      <= '0;
         bus.dReq   <= 1'b0;
         bus.dWe    <= 1'b0;
         bus.dAddr  <= '0;
         bus.dWdata <= '0;
         bus.dBe    <= '0;
         loadData   <= '0;
         busErr     <= 1'b0;
         misalign   <= 1'b0;
      end else begin
         busErr   <= 1'b0;
         misalign <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  bus.dAddr  <= {AluOut[31:2], 2'b00};
                  bus.dWdata <= wlane;
                  bus.dBe    <= be;
                  bus.dWe    <= memWrite;
                  bus.dReq   <= 1'b1;
                  fnc_q      <= fnc3;
                  off_q      <= AluOut[1:0];
                  wdog       <= '0;
                  state      <= BUSY;
               end else if (req && mis) begin
                  misalign <= 1'b1;
                  loadData <= '0;
               end
            end
            BUSY: begin
               if (bus.dAck) begin
                  if (!bus.dWe) loadData <= ext;
                  bus.dReq <= 1'b0;
                  state    <= DONE;
               end else if (wdog == 8'd254) begin
                  // 255th unacknowledged cycle: abandon, loadData untouched
                  wdog     <= 8'd255;
                  busErr   <= 1'b1;
                  bus.dReq <= 1'b0;
                  state    <= IDLE;
               end else begin
                  wdog <= wdog + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit against a size/offset arithmetic reference model.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] AluOut = '0, storeData = '0;
   logic [2:0]  fnc3 = '0;
   logic        memRead = 1'b0, memWrite = 1'b0;
   logic [31:0] loadData;
   logic        stall, busErr, misalign;
   int          tests = 0, fails = 0;
   logic [31:0] ld_model = '0;

   mem_access_unit_if bif ();

   mem_access_unit dut (
      .clk(clk), .rst(rst), .AluOut(AluOut), .storeData(storeData), .fnc3(fnc3),
      .memRead(memRead), .memWrite(memWrite), .bus(bif),
      .loadData(loadData), .stall(stall), .busErr(busErr), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] f3);
      int s;
      s = 1 << f3[1:0];
      return (s > 4) ? 4 : s;
   endfunction

   function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
      return (a % size_of(f3)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int eff_off(input logic [2:0] f3, input logic [31:0] a);
      int o;
      o = int'(a % 4);
      return o - (o % size_of(f3));
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rd);
      int     sz;
      longint v, span;
      sz   = size_of(f3);
      span = longint'(1) << (8 * sz);
      v    = longint'(rd >> (8 * eff_off(f3, a))) & (span - 1);
      if (!f3[2] && sz < 4 && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
      case (size_of(f3))
         1:       return 32'(sd[7:0]) * 32'h0101_0101;
         2:       return 32'(sd[15:0]) * 32'h0001_0001;
         default: return sd;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input bit wr, input logic [2:0] f3, input logic [31:0] a);
      if (!wr) return 4'hF;
      return 4'(((1 << size_of(f3)) - 1) << eff_off(f3, a));
   endfunction

   // One access from IDLE; dly = BUSY cycles before dAck, negative means never acknowledge.
   task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rdata, input int dly);
      int nreq;
      @(negedge clk);
      AluOut = a; storeData = sd; fnc3 = f3; memRead = rd; memWrite = wr;
      #1;
      if (model_mis(f3, a)) begin
         chk("stall_mis", 32'(stall), 0);
         @(posedge clk); #1;
         memRead = 1'b0; memWrite = 1'b0;
         ld_model = '0;
         chk("misalign_hi", 32'(misalign), 1);
         chk("dreq_mis", 32'(bif.dReq), 0);
         chk("ld_mis", loadData, ld_model);
         @(posedge clk); #1;
         chk("misalign_lo", 32'(misalign), 0);
         chk("dreq_mis2", 32'(bif.dReq), 0);
         return;
      end
      chk("stall_accept", 32'(stall), 1);
      @(posedge clk); #1;
      memRead = 1'b0; memWrite = 1'b0;
      chk("dAddr", bif.dAddr, a & 32'hFFFF_FFFC);
      chk("dWe", 32'(bif.dWe), 32'(wr));
      chk("dBe", 32'(bif.dBe), 32'(model_be(wr, f3, a)));
      if (wr) chk("dWdata", bif.dWdata, model_wdata(f3, sd));
      nreq = 0;
      for (int c = 0; c < 300; c++) begin
         if (!bif.dReq) break;
         nreq++;
         bif.dRdata = (nreq == dly + 1) ? rdata : $urandom;
         bif.dAck   = (nreq == dly + 1);
         @(posedge clk); #1;
         bif.dAck = 1'b0;
      end
      if (dly < 0) begin
         chk("timeout_cycles", 32'(nreq), 255);
         chk("busErr_hi", 32'(busErr), 1);
         chk("stall_err", 32'(stall), 0);
         chk("ld_err", loadData, ld_model);
         @(posedge clk); #1;
         chk("busErr_lo", 32'(busErr), 0);
         chk("dreq_err", 32'(bif.dReq), 0);
      end else begin
         if (!wr) ld_model = model_load(f3, a, rdata);
         chk("req_cycles", 32'(nreq), 32'(dly + 1));
         chk("stall_done", 32'(stall), 0);
         chk("loadData", loadData, ld_model);
         @(posedge clk);
      end
   endtask

   initial begin
      logic [2:0] f3tab [5];
      f3tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      bif.dAck = 1'b0; bif.dRdata = '0;
      #2;
      chk("rst_dReq", 32'(bif.dReq), 0);
      chk("rst_dWe", 32'(bif.dWe), 0);
      chk("rst_dAddr", bif.dAddr, 0);
      chk("rst_dWdata", bif.dWdata, 0);
      chk("rst_dBe", 32'(bif.dBe), 0);
      chk("rst_ld", loadData, 0);
      chk("rst_busErr", 32'(busErr), 0);
      chk("rst_misalign", 32'(misalign), 0);
      chk("rst_stall", 32'(stall), 0);
      @(negedge clk); rst = 1'b1;

      access(1, 0, 3'b010, 32'h100, 0, 32'hDEAD_BEEF, 1);
      chk("lw_const", loadData, 32'hDEAD_BEEF);
      access(0, 1, 3'b000, 32'h203, 32'h0000_00A5, 0, 0);
      chk("sb_addr", bif.dAddr, 32'h200);
      chk("sb_be", 32'(bif.dBe), 32'h8);
      chk("sb_wdata", bif.dWdata, 32'hA5A5_A5A5);
      chk("sb_we", 32'(bif.dWe), 1);
      chk("sb_ld_kept", loadData, 32'hDEAD_BEEF);
      access(1, 0, 3'b000, 32'h302, 0, 32'h0080_0000, 0);
      chk("lb_const", loadData, 32'hFFFF_FF80);
      access(1, 0, 3'b100, 32'h302, 0, 32'h0080_0000, 2);
      chk("lbu_const", loadData, 32'h0000_0080);

      // dAck outside BUSY must not touch loadData
      @(negedge clk); bif.dAck = 1'b1; bif.dRdata = 32'h1234_5678;
      @(negedge clk); bif.dAck = 1'b0;
      chk("ack_idle", loadData, ld_model);

      access(1, 0, 3'b010, 32'h101, 0, 32'hCAFE_F00D, 0);
`ifdef MISALIGN_TRAP_EN
      chk("lw_mis_ld", loadData, 0);
`else
      chk("lw_mis_addr", bif.dAddr, 32'h100);
      chk("lw_mis_ld", loadData, 32'hCAFE_F00D);
`endif
      access(1, 0, 3'b010, 32'h400, 0, 0, -1);

      // async reset in the middle of BUSY
      @(negedge clk);
      AluOut = 32'h500; fnc3 = 3'b010; memRead = 1'b1;
      @(posedge clk); #1; memRead = 1'b0;
      @(posedge clk); #3; rst = 1'b0; #1;
      ld_model = '0;
      chk("rst_mid_dReq", 32'(bif.dReq), 0);
      chk("rst_mid_stall", 32'(stall), 0);
      chk("rst_mid_ld", loadData, 0);
      @(negedge clk); rst = 1'b1;
      access(1, 0, 3'b010, 32'h504, 0, 32'h0BAD_F00D, 1);

      for (int n = 0; n < 40; n++) begin
         int k;
         k = $urandom_range(0, 2);
         access(k != 1, k != 0, f3tab[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
                $urandom_range(0, 4));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 AluOut  input  32  byte address from the EX/MEM register.
REQ-005 storeData  input  32  store data from the EX/MEM register.
REQ-006 fnc3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 memRead, memWrite  input  1 each  access request from the EX/MEM register.
REQ-008 dAddr  output  32  word-aligned bus address ({AluOut[31:2],2'b00}).
REQ-009 dWdata  output  32  lane-replicated store data.
REQ-010 dBe  output  4  byte enables.
REQ-011 dWe  output  1  1 = write, 0 = read.
REQ-012 dReq  output  1  bus request.
REQ-013 dAck  input  1  bus completion; dRdata is valid in the same cycle.
REQ-014 dRdata  input  32  bus read data.
REQ-015 loadData  output  32  extended load result.
REQ-016 stall  output  1  freezes the upstream pipeline registers.
REQ-017 busErr  output  1  one-cycle pulse on timeout.
REQ-018 misalign  output  1  one-cycle pulse on a misaligned access.

Function
REQ-019 FSM states: IDLE, BUSY, DONE.
REQ-020 IDLE with memRead|memWrite, and the access not suppressed by REQ-031, SHALL register dAddr/dWdata/dBe/dWe and move to BUSY.
REQ-021 memRead and memWrite high together SHALL be treated as a write.
REQ-022 dReq SHALL be 1 exactly while in BUSY, with bus outputs held stable.
REQ-023 BUSY with dAck=1 SHALL capture the extended dRdata into loadData (reads only) and move to DONE.
REQ-024 DONE SHALL return to IDLE unconditionally after one cycle.
REQ-025 stall (combinational) SHALL be 1 in IDLE with an accepted request, and throughout BUSY.
  - stall SHALL be 0 in DONE; minimum access latency is 3 cycles (IDLE, BUSY, DONE).
REQ-026 dAck SHALL be ignored outside BUSY.
REQ-027 An 8-bit watchdog SHALL clear on entry to BUSY and increment each BUSY cycle without dAck.
  - On reaching 255: pulse busErr, return to IDLE, leave loadData unchanged.
REQ-028 Byte enables and store lanes:
  - SB: dBe=1<<AluOut[1:0], byte replicated on all 4 lanes.
  - SH: dBe=AluOut[1]?1100:0011, halfword replicated on both halves.
  - SW: dBe=1111.
  - Reads drive dBe=1111.
REQ-029 Load extraction SHALL select the byte/halfword by AluOut[1:0]; zero-extend when fnc3[2]=1, sign-extend otherwise.

Reset
REQ-030 rst low SHALL immediately force:
  - state IDLE, watchdog 0;
  - dReq, dWe, busErr, misalign = 0;
  - dAddr, dWdata, dBe, loadData = 0.
  - Reset mid-BUSY SHALL abandon the transaction, with dReq deasserted asynchronously.

Configuration
REQ-031 With MISALIGN_TRAP_EN defined, a halfword with AluOut[0]=1 or a word with AluOut[1:0]!=0 SHALL raise no bus request.
  - misalign SHALL pulse for one cycle, stall SHALL stay 0, and loadData SHALL be set to 0.
REQ-032 Without MISALIGN_TRAP_EN, misalign SHALL be tied 0 and misaligned accesses SHALL proceed.
  - Halfwords use AluOut[1] only; words are forced to the aligned word.

Verification
REQ-033 LW: AluOut=0x100, dAck in 2nd BUSY cycle, dRdata=0xDEADBEEF -> dReq 2 cycles, loadData=0xDEADBEEF, stall low in DONE.
REQ-034 SB: AluOut=0x203, storeData=0x000000A5 -> dAddr=0x200, dBe=1000, dWdata=0xA5A5A5A5, dWe=1.
REQ-035 LB and LBU: AluOut=0x302, dRdata=0x00800000 -> LB loadData=0xFFFFFF80; LBU loadData=0x00000080.
REQ-036 Read with no dAck -> busErr pulses after 255 BUSY cycles, FSM in IDLE, stall 0.
REQ-037 MISALIGN_TRAP_EN: LW at 0x101 -> misalign 1 cycle, dReq never 1, loadData=0.
  - Without the macro: same access reads 0x100.
REQ-038 rst low in mid-BUSY -> dReq 0 immediately; after release, a new LW completes normally.
